th_cmd_receiver: RTL

//  Harness-side end of the host->FPGA test-command link. Deserializes UART bytes into packets
//  {Opcode, Addr, Data, Delay}, buffers them, then replays them on a valid/ready command port

---
 rtl/th_cmd_pkg.sv | 31 +++
 rtl/th_cmd_fifo.sv | 49 ++++
 rtl/th_cmd_receiver.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/th_cmd_pkg.sv
// Shared test-harness definitions for the host->FPGA command link.
// Contents:
//   - default field widths and the packet width TH_PW;
//   - opcode constants (WRITE, READ, READRMV, START marker);
//   - receiver state encoding (ST_LOAD, ST_REPLAY, ST_DONE);
//   - thPacketBytes(): number of serial bytes that make up one packet.
package th_cmd_pkg;

  localparam int TH_UART_W = 8;
  localparam int TH_OP_W   = 8;
  localparam int TH_ADDR_W = 32;
  localparam int TH_DATA_W = 32;
  localparam int TH_TIME_W = 32;
  localparam int TH_PW     = TH_OP_W + TH_ADDR_W + TH_DATA_W + TH_TIME_W;

  localparam logic [7:0] TH_OP_WRITE   = 8'h00;
  localparam logic [7:0] TH_OP_READ    = 8'h01;
  localparam logic [7:0] TH_OP_READRMV = 8'h02;
  localparam logic [7:0] TH_OP_START   = 8'hFF;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_REPLAY = 2'd1,
    ST_DONE   = 2'd2
  } thState_e;

  function automatic int thPacketBytes(input int packetW, input int byteW);
    return (packetW + byteW - 1) / byteW;
  endfunction

endpackage

// File: rtl/th_cmd_fifo.sv
// Command buffer for th_cmd_receiver: synchronous FIFO, Depth entries of
// Width bits, first-word-fall-through (Head shows the oldest entry whenever
// Empty is low). Push while Full and Pop while Empty are ignored.
// Ports:
//   Clock, Reset      clock, synchronous active-high reset (clears pointers)
//   Push, PushData    write one entry
//   Pop               discard the head entry
//   Head              current head entry
//   Full, Empty       occupancy flags
module th_cmd_fifo #(
  parameter int Width = 104,
  parameter int Depth = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Push,
  input  logic [Width-1:0] PushData,
  input  logic             Pop,
  output logic [Width-1:0] Head,
  output logic             Full,
  output logic             Empty
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (Push && !Full)  wrPtr <= wrPtr + (AW+1)'(1);
      if (Pop  && !Empty) rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Push && !Full) mem[wrPtr[AW-1:0]] <= PushData;
  end

  assign Empty = (wrPtr == rdPtr);
  assign Full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign Head  = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/th_cmd_receiver.sv
// Harness-side receiver of the host->FPGA test-command link.
// Bytes arriving on InData/InValid/InReady (MSB first) are assembled into
// {Opcode, Addr, Data, Delay} packets and buffered. An opcode 0xFF packet is
// the START marker: it is not stored, and the buffered commands are then
// replayed on the Cmd* valid/ready port, each one Delay cycles after the
// previous handshake (the first one Delay cycles after START).
// Ports:
//   Clock, Reset                 clock, synchronous active-high reset
//   InData, InValid, InReady     serial-side byte stream
//   CmdOp, CmdAddr, CmdData      replayed command
//   CmdValid, CmdReady           command handshake
//   Replaying                    high while replaying
//   Done                         one-cycle pulse after the last handshake
//   Overflow                     sticky: a packet was dropped on a full buffer
// Build option:
//   TH_CMD_TIMEOUT_EN  discard a partial packet after TimeoutCycles idle
//                      cycles; when undefined a partial packet waits forever.
module th_cmd_receiver
  import th_cmd_pkg::*;
#(
  parameter int UARTWidth     = 8,
  parameter int OpWidth       = 8,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeWidth     = 32,
  parameter int Depth         = 16,
  parameter int TimeoutCycles = 1_000_000
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [UARTWidth-1:0] InData,
  input  logic                 InValid,
  output logic                 InReady,
  output logic [OpWidth-1:0]   CmdOp,
  output logic [AddrWidth-1:0] CmdAddr,
  output logic [DataWidth-1:0] CmdData,
  output logic                 CmdValid,
  input  logic                 CmdReady,
  output logic                 Replaying,
  output logic                 Done,
  output logic                 Overflow
);

  localparam int PW       = OpWidth + AddrWidth + DataWidth + TimeWidth;
  localparam int NumBytes = thPacketBytes(PW, UARTWidth);
  localparam int CntW     = $clog2(NumBytes);

  thState_e state;
  thState_e stateNext;

  logic [CntW-1:0]      byteCnt;
  logic [PW-1:0]        asmReg;
  logic [PW-1:0]        packetNext;
  logic [TimeWidth-1:0] delayCnt;

  logic byteAccept;
  logic pktDone;
  logic isStart;
  logic handshake;

  logic          fifoPush;
  logic          fifoPop;
  logic [PW-1:0] fifoHead;
  logic          fifoFull;
  logic          fifoEmpty;

  logic [OpWidth-1:0]   headOp;
  logic [AddrWidth-1:0] headAddr;
  logic [DataWidth-1:0] headData;
  logic [TimeWidth-1:0] headDelay;

  // Byte assembly
  assign InReady    = (state == ST_LOAD);
  assign byteAccept = InValid && InReady;
  assign packetNext = {asmReg[PW-UARTWidth-1:0], InData};
  assign pktDone    = byteAccept && (byteCnt == CntW'(NumBytes-1));
  assign isStart    = (packetNext[PW-1 -: OpWidth] == OpWidth'(TH_OP_START));
  assign handshake  = CmdValid && CmdReady;

  always_ff @(posedge Clock) begin
    if (byteAccept) asmReg <= packetNext;
  end

  // Command buffer
  assign fifoPush = pktDone && !isStart && !fifoFull;
  // The first entry is popped on the START byte itself so its Delay is
  // counted from START; later entries are popped on each handshake.
  assign fifoPop  = !fifoEmpty &&
                    ((pktDone && isStart) || ((state == ST_REPLAY) && handshake));

  th_cmd_fifo #(
    .Width (PW),
    .Depth (Depth)
  ) uFifo (
    .Clock    (Clock),
    .Reset    (Reset),
    .Push     (fifoPush),
    .PushData (packetNext),
    .Pop      (fifoPop),
    .Head     (fifoHead),
    .Full     (fifoFull),
    .Empty    (fifoEmpty)
  );

  assign headOp    = fifoHead[PW-1 -: OpWidth];
  assign headAddr  = fifoHead[PW-OpWidth-1 -: AddrWidth];
  assign headData  = fifoHead[TimeWidth+DataWidth-1 -: DataWidth];
  assign headDelay = fifoHead[TimeWidth-1:0];

  // Control FSM
  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_LOAD;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_LOAD:   if (pktDone && isStart) stateNext = fifoEmpty ? ST_DONE : ST_REPLAY;
      ST_REPLAY: if (handshake && fifoEmpty) stateNext = ST_DONE;
      ST_DONE:   stateNext = ST_LOAD;
      default:   stateNext = ST_LOAD;
    endcase
  end

  assign Replaying = (state == ST_REPLAY);
  assign Done      = (state == ST_DONE);

  // Byte counter, delay counter and replay outputs
`ifdef TH_CMD_TIMEOUT_EN
  localparam int IdleW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  logic [IdleW-1:0] idleCnt;
  logic             idleTick;

  assign idleTick = (state == ST_LOAD) && (byteCnt != '0) && !byteAccept;

  always_ff @(posedge Clock) begin
    if (Reset)         idleCnt <= '0;
    else if (!idleTick) idleCnt <= '0;
    else if (idleCnt == IdleW'(TimeoutCycles-1)) idleCnt <= '0;
    else               idleCnt <= idleCnt + IdleW'(1);
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      byteCnt  <= '0;
      delayCnt <= '0;
      CmdOp    <= '0;
      CmdAddr  <= '0;
      CmdData  <= '0;
      CmdValid <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      if (byteAccept) begin
        byteCnt <= pktDone ? '0 : byteCnt + CntW'(1);
      end
`ifdef TH_CMD_TIMEOUT_EN
      else if (idleTick && (idleCnt == IdleW'(TimeoutCycles-1))) begin
        byteCnt <= '0;
      end
`endif

      if (pktDone && !isStart && fifoFull) Overflow <= 1'b1;

      if (fifoPop) begin
        CmdOp    <= headOp;
        CmdAddr  <= headAddr;
        CmdData  <= headData;
        delayCnt <= headDelay;
        CmdValid <= 1'b0;
      end else if (state == ST_REPLAY) begin
        if (handshake) begin
          CmdValid <= 1'b0;
        end else if (!CmdValid) begin
          // Valid rises the cycle after the counter has reached zero.
          if (delayCnt == '0) CmdValid <= 1'b1;
          else                delayCnt <= delayCnt - TimeWidth'(1);
        end
      end
    end
  end

endmodule
